uart_boot_loader: RTL and testbench

Serial boot loader upstream of the FPGA platform's CPU and program BRAM. It receives a program image over the UART RX line and writes it, one 32-bit word at a time, into the BRAM data port while holding the CPU in reset. It releases the CPU once the declared byte count has been stored. The image format is a sync byte, a 32-bit little-endian length, then the payload bytes.

---
 rtl/uart_boot_loader.sv | 203 ++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_boot_loader
//  Purpose  : Receives a sync/length/payload image over 8N1 UART and writes it
//             word by word into program BRAM, holding the CPU in reset until
//             the declared byte count has been stored.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_boot_loader #(
    parameter int          CLKS_PER_BIT_UART = 868,
    parameter logic [31:0] BASE_ADDR         = 32'h0000_0000,
    parameter int          MAX_BYTES         = 65536,
    parameter logic [7:0]  SYNC_BYTE         = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        uart_rx_i,
    output logic        mem_en_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        cpu_reset_n_o,
    output logic        busy_o,
    output logic        error_o
);

    localparam int                 c_cnt_w = $clog2(CLKS_PER_BIT_UART);
    localparam logic [c_cnt_w-1:0] c_half  = c_cnt_w'(CLKS_PER_BIT_UART / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(CLKS_PER_BIT_UART - 1);
    localparam logic [31:0]        c_max   = 32'(MAX_BYTES);

    localparam logic [1:0] c_rx_idle  = 2'd0;
    localparam logic [1:0] c_rx_start = 2'd1;
    localparam logic [1:0] c_rx_data  = 2'd2;
    localparam logic [1:0] c_rx_stop  = 2'd3;

    localparam logic [2:0] c_st_sync  = 3'd0;
    localparam logic [2:0] c_st_len   = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_done  = 3'd3;
    localparam logic [2:0] c_st_error = 3'd4;

    logic               r_rx_meta, r_rx_sync, r_rx_prev;
    logic [1:0]         r_rx_state;
    logic [c_cnt_w-1:0] r_rx_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_rx_byte;
    logic               r_byte_valid, r_frame_err;

    logic [2:0]  r_state;
    logic [31:0] r_cnt, r_len, r_buf;
    logic [3:0]  r_mask;

    logic        w_fall;
    logic [1:0]  w_lane;
    logic [31:0] w_len_shift, w_buf_new, w_cnt_inc;
    logic [3:0]  w_mask_new;
    logic        w_last;

    assign w_fall      = r_rx_prev & ~r_rx_sync;
    assign w_lane      = r_cnt[1:0];
    assign w_len_shift = {r_rx_byte, r_len[31:8]};
    assign w_buf_new   = r_buf | ({24'd0, r_rx_byte} << {w_lane, 3'b000});
    assign w_mask_new  = r_mask | (4'b0001 << w_lane);
    assign w_cnt_inc   = r_cnt + 32'd1;
    assign w_last      = (w_cnt_inc == r_len);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Mid-bit sampling receiver; returns to idle right after the stop sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_state   <= c_rx_idle;
            r_rx_cnt     <= '0;
            r_bit_idx    <= 3'd0;
            r_rx_byte    <= 8'd0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                c_rx_idle: begin
                    if (w_fall) begin
                        r_rx_cnt   <= c_half;
                        r_rx_state <= c_rx_start;
                    end
                end
                c_rx_start: begin
                    if (r_rx_cnt == '0) begin
                        if (r_rx_sync) begin
                            r_rx_state <= c_rx_idle;
                        end else begin
                            r_rx_cnt   <= c_full;
                            r_bit_idx  <= 3'd0;
                            r_rx_state <= c_rx_data;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                c_rx_data: begin
                    if (r_rx_cnt == '0) begin
                        r_rx_byte <= {r_rx_sync, r_rx_byte[7:1]};
                        r_rx_cnt  <= c_full;
                        if (r_bit_idx == 3'd7) r_rx_state <= c_rx_stop;
                        else                   r_bit_idx  <= r_bit_idx + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                default: begin
                    if (r_rx_cnt == '0) begin
                        r_byte_valid <= r_rx_sync;
                        r_frame_err  <= ~r_rx_sync;
                        r_rx_state   <= c_rx_idle;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_st_sync;
            r_cnt      <= 32'd0;
            r_len      <= 32'd0;
            r_buf      <= 32'd0;
            r_mask     <= 4'd0;
            mem_en_o   <= 1'b0;
            mem_we_o   <= 4'd0;
            mem_addr_o <= BASE_ADDR;
            mem_data_o <= 32'd0;
        end else begin
            mem_en_o <= 1'b0;
            case (r_state)
                c_st_sync: begin
                    if (r_byte_valid && r_rx_byte == SYNC_BYTE) begin
                        r_state <= c_st_len;
                        r_cnt   <= 32'd0;
                    end
                end
                c_st_len: begin
                    if (r_frame_err) begin
                        r_state <= c_st_error;
                    end else if (r_byte_valid) begin
                        r_len <= w_len_shift;
                        r_cnt <= w_cnt_inc;
                        if (r_cnt[1:0] == 2'd3) begin
                            r_cnt  <= 32'd0;
                            r_buf  <= 32'd0;
                            r_mask <= 4'd0;
                            if (w_len_shift == 32'd0)     r_state <= c_st_done;
                            else if (w_len_shift > c_max) r_state <= c_st_error;
                            else                          r_state <= c_st_data;
                        end
                    end
                end
                c_st_data: begin
                    if (r_frame_err) begin
                        r_state <= c_st_error;
                    end else if (r_byte_valid) begin
                        r_cnt <= w_cnt_inc;
                        if (w_lane == 2'd3 || w_last) begin
                            mem_en_o   <= 1'b1;
                            mem_we_o   <= w_mask_new;
                            mem_data_o <= w_buf_new;
                            mem_addr_o <= BASE_ADDR + {r_cnt[31:2], 2'b00};
                            r_buf      <= 32'd0;
                            r_mask     <= 4'd0;
                            if (w_last) r_state <= c_st_done;
                        end else begin
                            r_buf  <= w_buf_new;
                            r_mask <= w_mask_new;
                        end
                    end
                end
                c_st_done, c_st_error: begin
                    r_state <= r_state;
                end
                default: r_state <= c_st_sync;
            endcase
        end
    end

    assign cpu_reset_n_o = (r_state == c_st_done);
    assign error_o       = (r_state == c_st_error);
    assign busy_o        = (r_state == c_st_len) || (r_state == c_st_data);

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_boot_loader
//  Purpose  : Directed frames with a scoreboard of expected BRAM writes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_boot_loader;

    localparam int          c_clks = 8;
    localparam logic [31:0] c_base = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        uart_rx_i = 1'b1;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic        cpu_reset_n_o, busy_o, error_o;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    uart_boot_loader #(
        .CLKS_PER_BIT_UART(c_clks),
        .BASE_ADDR        (c_base),
        .MAX_BYTES        (65536),
        .SYNC_BYTE        (8'hA5)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .uart_rx_i    (uart_rx_i),
        .mem_en_o     (mem_en_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .cpu_reset_n_o(cpu_reset_n_o),
        .busy_o       (busy_o),
        .error_o      (error_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (mem_en_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", mem_addr_o, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr_o, e.addr);
                check("wr_we", {28'd0, mem_we_o}, {28'd0, e.we});
                check("wr_data", mem_data_o, e.data);
                check("wr_cpu_release", {31'd0, cpu_reset_n_o}, {31'd0, e.last});
                check("wr_busy", {31'd0, busy_o}, {31'd0, ~e.last});
            end
        end
    end

    task automatic push(input logic [31:0] addr, input logic [3:0] we,
                        input logic [31:0] data, input logic last);
        exp_t e;
        e.addr = addr; e.we = we; e.data = data; e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        uart_rx_i = 1'b0;
        repeat (c_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (c_clks) @(negedge clk);
        end
        uart_rx_i = bad_stop ? 1'b0 : 1'b1;
        repeat (c_clks) @(negedge clk);
        uart_rx_i = 1'b1;
    endtask

    task automatic send_bytes(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i], 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_outputs(input string tag, input logic cpu, input logic busy, input logic err);
        check({tag, "_cpu"}, {31'd0, cpu_reset_n_o}, {31'd0, cpu});
        check({tag, "_busy"}, {31'd0, busy_o}, {31'd0, busy});
        check({tag, "_err"}, {31'd0, error_o}, {31'd0, err});
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_en"}, {31'd0, mem_en_o}, 32'd0);
        check({tag, "_we"}, {28'd0, mem_we_o}, 32'd0);
        check({tag, "_addr"}, mem_addr_o, c_base);
        check({tag, "_data"}, mem_data_o, 32'd0);
        check_outputs(tag, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_frame1();
        push(c_base,         4'hF, 32'h4433_2211, 1'b0);
        push(c_base + 32'd4, 4'hF, 32'h8877_6655, 1'b1);
    endtask

    initial begin
        logic [7:0] frame1[$] = '{8'hA5, 8'h08, 8'h00, 8'h00, 8'h00,
                                  8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        logic [7:0] frame2[$] = '{8'hA5, 8'h05, 8'h00, 8'h00, 8'h00,
                                  8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        logic [7:0] frame0[$] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [7:0] garbage[$] = '{8'h00, 8'hFF};
        logic [7:0] toolong[$] = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00};
        logic [7:0] head6[$]   = '{8'hA5, 8'h08, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        logic [7:0] len8[$]    = '{8'h08, 8'h00, 8'h00, 8'h00,
                                  8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full 8-byte image, two complete words
        push_frame1();
        send_bytes(frame1);
        repeat (4) @(negedge clk);
        check_outputs("frame8", 1'b1, 1'b0, 1'b0);

        // Partial final word
        do_reset();
        check_reset_state("rst2");
        push(c_base,         4'hF, 32'h0403_0201, 1'b0);
        push(c_base + 32'd4, 4'h1, 32'h0000_0005, 1'b1);
        send_bytes(frame2);
        repeat (4) @(negedge clk);
        check_outputs("frame5", 1'b1, 1'b0, 1'b0);

        // Zero length releases CPU with no write
        do_reset();
        send_bytes(frame0);
        repeat (2) @(negedge clk);
        check_outputs("len0", 1'b1, 1'b0, 1'b0);

        // Leading garbage discarded
        do_reset();
        push_frame1();
        send_bytes(garbage);
        send_bytes(frame1);
        repeat (4) @(negedge clk);
        check_outputs("garbage", 1'b1, 1'b0, 1'b0);

        // Oversized length, then recovery after reset
        do_reset();
        send_bytes(toolong);
        repeat (4) @(negedge clk);
        check_outputs("toolong", 1'b0, 1'b0, 1'b1);
        do_reset();
        check_reset_state("rst_err");
        push(c_base,         4'hF, 32'h0403_0201, 1'b0);
        push(c_base + 32'd4, 4'h1, 32'h0000_0005, 1'b1);
        send_bytes(frame2);
        repeat (4) @(negedge clk);
        check_outputs("recover", 1'b1, 1'b0, 1'b0);

        // Framing error on third payload byte
        do_reset();
        send_bytes(head6);
        send_byte(8'h33, 1'b1);
        repeat (4) @(negedge clk);
        check_outputs("framing", 1'b0, 1'b0, 1'b1);

        // One-cycle glitch while collecting length must not produce a byte
        do_reset();
        push_frame1();
        send_byte(8'hA5, 1'b0);
        repeat (2 * c_clks) @(negedge clk);
        uart_rx_i = 1'b0;
        @(negedge clk);
        uart_rx_i = 1'b1;
        repeat (3 * c_clks) @(negedge clk);
        check("glitch_busy", {31'd0, busy_o}, 32'd1);
        send_bytes(len8);
        repeat (4) @(negedge clk);
        check_outputs("glitch", 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
